// File: rtl/simple_machine_pkg.sv
// Shared definitions for the simple machine: instruction layout, opcodes and fetcher states.
package simple_machine_pkg;

   localparam int unsigned INSTR_W = 20;

   typedef logic [INSTR_W-1:0] instr_t;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_HALT   = 4'hF;
   localparam instr_t     NOP_INSTR = '0;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_FETCH,
      FS_LOAD,
      FS_ISSUE,
      FS_EXEC,
      FS_HALT
   } fetch_state_e;

   function automatic logic [3:0] instr_op(input instr_t i);
      return i[19:16];
   endfunction

   function automatic logic [7:0] instr_a(input instr_t i);
      return i[15:8];
   endfunction

   function automatic logic [7:0] instr_b(input instr_t i);
      return i[7:0];
   endfunction

endpackage

// File: rtl/instruction_fetcher.sv
// Walks the program ROM and hands one instruction at a time to the executor, retiring on Done.
// Optional single-step mode is enabled by defining FETCH_STEP_EN (adds the Step input).
module instruction_fetcher
   import simple_machine_pkg::*;
#(
   parameter int unsigned  P        = 4,
   parameter logic [P-1:0] RESET_PC = '0
) (
   input  logic               Clock,
   input  logic               ResetN,
   input  logic               Run,
`ifdef FETCH_STEP_EN
   input  logic               Step,
`endif
   output logic [P-1:0]       ProgAddr,
   input  logic [INSTR_W-1:0] ProgData,
   output logic [INSTR_W-1:0] OpCode,
   input  logic               Done,
   output logic [P-1:0]       Pc,
   output logic               Halted,
   output logic [15:0]        Retired
);

   fetch_state_e state_q, state_d;
   logic [P-1:0] pc_q, pc_d;
   instr_t       ir_q, ir_d;
   logic         halted_q, halted_d;
   logic [15:0]  retired_q, retired_d;
   logic         start_ok;
   logic         stay_busy;

`ifdef FETCH_STEP_EN
   // Single-step: every instruction needs its own Step while IDLE.
   assign start_ok  = Run & Step;
   assign stay_busy = 1'b0;
`else
   assign start_ok  = Run;
   assign stay_busy = Run;
`endif

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q   <= FS_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= NOP_INSTR;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         halted_q  <= halted_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      halted_d  = halted_q;
      retired_d = retired_q;
      unique case (state_q)
         FS_IDLE: begin
            if (start_ok) state_d = FS_FETCH;
         end
         FS_FETCH: state_d = FS_LOAD;
         FS_LOAD: begin
            ir_d = ProgData;
            // HALT leaves Pc on the HALT word itself.
            if (instr_op(ProgData) == OP_HALT) begin
               halted_d = 1'b1;
               state_d  = FS_HALT;
            end else begin
               pc_d    = pc_q + P'(1);
               state_d = FS_ISSUE;
            end
         end
         FS_ISSUE: state_d = FS_EXEC;
         FS_EXEC: begin
            if (Done) begin
               retired_d = retired_q + 16'd1;
               state_d   = stay_busy ? FS_FETCH : FS_IDLE;
            end
         end
         FS_HALT: state_d = FS_HALT;
         default: state_d = FS_IDLE;
      endcase
   end

   // Masking OpCode as soon as Done rises keeps the executor from restarting the same instruction.
   always_comb begin
      OpCode = NOP_INSTR;
      unique case (state_q)
         FS_ISSUE: OpCode = ir_q;
         FS_EXEC:  OpCode = Done ? NOP_INSTR : ir_q;
         default:  OpCode = NOP_INSTR;
      endcase
   end

   assign ProgAddr = pc_q;
   assign Pc       = pc_q;
   assign Halted   = halted_q;
   assign Retired  = retired_q;

endmodule
